// File: rtl/max_pool_2x2_if.sv
// Command, staging-buffer read and output-SRAM write bundle for the 2x2 max-pool block.
// The master side is the controller/testbench; the slave side is max_pool_2x2.
interface max_pool_2x2_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
);
    logic              op_valid;
    logic [2:0]        op;
    logic              ack;
    logic              data_NA;
    logic [DIM_W-1:0]  channel;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_DI;
    logic              wr_wen;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_DO;
    logic              done;

    modport master (
        output op_valid, op, channel, row, col, rd_DI,
        input  ack, data_NA, rd_addr, wr_wen, wr_addr, wr_DO, done
    );

    modport slave (
        input  op_valid, op, channel, row, col, rd_DI,
        output ack, data_NA, rd_addr, wr_wen, wr_addr, wr_DO, done
    );
endinterface

// File: rtl/max_pool_2x2.sv
// Signed int8 2x2 / stride-2 max pool over one channel slice of the staging buffer,
// one pooled output word per pair of input rows, one channel per start command.
module max_pool_2x2 #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    max_pool_2x2_if.slave bus
);
    localparam int NL = WORD_W / 8;
    localparam int NP = NL / 2;
    localparam logic [2:0] OP_CFG   = 3'b001;
    localparam logic [2:0] OP_START = 3'b011;

    typedef enum logic [1:0] {IDLE, RD_A, RD_B, WR} state_t;

    state_t            state_reg, state_next;
    logic              ack_reg, ack_next;
    logic              data_na_reg, data_na_next;
    logic              done_reg, done_next;
    logic              wr_wen_reg, wr_wen_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [WORD_W-1:0] wr_do_reg, wr_do_next;
    logic [DIM_W-1:0]  ch_reg, ch_next;
    logic [DIM_W-1:0]  r_reg, r_next;
    logic [DIM_W-1:0]  channel_reg, channel_next;
    logic [DIM_W-1:0]  row_reg, row_next;
    logic [DIM_W-1:0]  col_reg, col_next;
    logic [WORD_W-1:0] row_a_reg, row_a_next;

    logic [DIM_W-1:0]   col_eff;
    logic [DIM_W-1:0]   pairs;
    logic [DIM_W-1:0]   half_rows;
    logic [2*DIM_W-1:0] in_prod;
    logic [2*DIM_W-1:0] out_prod;
    logic [ADDR_W-1:0]  in_base;
    logic [ADDR_W-1:0]  out_base;
    logic [WORD_W-1:0]  pooled;

    // Lanes beyond the word are clamped away; an odd trailing lane has no partner.
    assign col_eff   = (col_reg > DIM_W'(NL)) ? DIM_W'(NL) : col_reg;
    assign pairs     = col_eff >> 1;
    assign half_rows = row_reg >> 1;

    assign in_prod  = {{DIM_W{1'b0}}, ch_reg} * {{DIM_W{1'b0}}, row_reg};
    assign out_prod = {{DIM_W{1'b0}}, ch_reg} * {{DIM_W{1'b0}}, half_rows};
    assign in_base  = ADDR_W'(in_prod);
    assign out_base = ADDR_W'(out_prod);

    assign bus.rd_addr = in_base + ADDR_W'({r_reg, 1'b0}) + ADDR_W'(state_reg == RD_B);

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_lane
            if (gi < NP) begin : g_pool
                logic signed [7:0] a0, a1, b0, b1, m0, m1, mx;
                assign a0 = row_a_reg[16*gi +: 8];
                assign a1 = row_a_reg[16*gi+8 +: 8];
                assign b0 = bus.rd_DI[16*gi +: 8];
                assign b1 = bus.rd_DI[16*gi+8 +: 8];
                assign m0 = (a0 > a1) ? a0 : a1;
                assign m1 = (b0 > b1) ? b0 : b1;
                assign mx = (m0 > m1) ? m0 : m1;
                assign pooled[8*gi +: 8] = (DIM_W'(gi) < pairs) ? mx : 8'h00;
            end else begin : g_zero
                assign pooled[8*gi +: 8] = 8'h00;
            end
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        ack_next     = 1'b0;
        done_next    = 1'b0;
        wr_wen_next  = 1'b0;
        data_na_next = data_na_reg;
        wr_addr_next = wr_addr_reg;
        wr_do_next   = wr_do_reg;
        ch_next      = ch_reg;
        r_next       = r_reg;
        channel_next = channel_reg;
        row_next     = row_reg;
        col_next     = col_reg;
        row_a_next   = row_a_reg;

        case (state_reg)
            IDLE: begin
                if (bus.op_valid) begin
                    if (bus.op == OP_CFG) begin
                        ack_next     = 1'b1;
                        channel_next = bus.channel;
                        row_next     = bus.row;
                        col_next     = bus.col;
                        ch_next      = '0;
                        data_na_next = 1'b0;
                    end else if (bus.op == OP_START) begin
                        ack_next = 1'b1;
                        if (ch_reg == channel_reg) begin
                            data_na_next = 1'b1;
                        end else if (row_reg < DIM_W'(2) || col_reg < DIM_W'(2)) begin
                            // Nothing to pool: consume the channel without touching memory.
                            done_next = 1'b1;
                            ch_next   = ch_reg + DIM_W'(1);
                        end else begin
                            r_next     = '0;
                            state_next = RD_A;
                        end
                    end
                end
            end
            RD_A: begin
                state_next = RD_B;
            end
            RD_B: begin
                row_a_next = bus.rd_DI;
                state_next = WR;
            end
            WR: begin
                wr_wen_next  = 1'b1;
                wr_addr_next = out_base + ADDR_W'(r_reg);
                wr_do_next   = pooled;
                if (r_reg == half_rows - DIM_W'(1)) begin
                    done_next  = 1'b1;
                    ch_next    = ch_reg + DIM_W'(1);
                    state_next = IDLE;
                end else begin
                    r_next     = r_reg + DIM_W'(1);
                    state_next = RD_A;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ack_reg     <= 1'b0;
            data_na_reg <= 1'b0;
            done_reg    <= 1'b0;
            wr_wen_reg  <= 1'b0;
            wr_addr_reg <= '0;
            wr_do_reg   <= '0;
            ch_reg      <= '0;
            r_reg       <= '0;
            channel_reg <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            row_a_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            ack_reg     <= ack_next;
            data_na_reg <= data_na_next;
            done_reg    <= done_next;
            wr_wen_reg  <= wr_wen_next;
            wr_addr_reg <= wr_addr_next;
            wr_do_reg   <= wr_do_next;
            ch_reg      <= ch_next;
            r_reg       <= r_next;
            channel_reg <= channel_next;
            row_reg     <= row_next;
            col_reg     <= col_next;
            row_a_reg   <= row_a_next;
        end
    end

    assign bus.ack     = ack_reg;
    assign bus.data_NA = data_na_reg;
    assign bus.done    = done_reg;
    assign bus.wr_wen  = wr_wen_reg;
    assign bus.wr_addr = wr_addr_reg;
    assign bus.wr_DO   = wr_do_reg;
endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Downstream consumer of the max-controller staging buffer: once a channel slice of `row` packed words has been written and `data_ready` reported, this block reads that slice back, computes a signed 2x2 / stride-2 max pool, and writes one pooled word per pair of input rows to the output SRAM. It is driven by the same `op_valid`/`op`/`ack`/`data_NA` command protocol and processes one channel per start command.

## Interface
Parameters:
- WORD_W, 32: SRAM word width; packs WORD_W/8 signed int8 lanes. Lane k is bits [8k+7:8k].
- ADDR_W, 16: SRAM word address width.
- DIM_W, 8: width of channel/row/col dimensions.

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  command strobe.
- op  in  3  3'b001 = config, 3'b011 = start pool of the next channel; other codes are ignored.
- ack  out  1  one-cycle pulse per accepted command.
- data_NA  out  1  set when a start arrives after all channels are done; cleared by config.
- channel, row, col  in  DIM_W  tensor dimensions, latched on config.
- rd_addr  out  ADDR_W  input buffer read address; synchronous read, data returns next cycle.
- rd_DI  in  WORD_W  input buffer read data.
- wr_wen  out  1  output SRAM write strobe, active high.
- wr_addr  out  ADDR_W  output write address.
- wr_DO  out  WORD_W  pooled word.
- done  out  1  one-cycle pulse when the current channel is finished.

## Operation
- Reset: ack, data_NA, wr_wen, done = 0. wr_addr, wr_DO = 0. Channel index, row counter and dims = 0. State IDLE. rd_addr = 0.
- States: IDLE, RD_A, RD_B, WR.
- **IDLE, config:**
  - Latch channel, row, col.
  - Clear the channel index and data_NA.
  - Pulse ack. Stay in IDLE.
- **IDLE, start:**
  - Pulse ack.
  - If the channel index equals `channel`: set data_NA and stay in IDLE.
  - Else if row<2 or col<2: pulse done in the next cycle, increment the channel index, issue no reads or writes.
  - Else: set r=0 and go to RD_A.
- Commands received outside IDLE are ignored; no ack.
- rd_addr = in_base + 2r + (state==RD_B).
  - in_base = ch*row.
  - In other states rd_addr holds the RD_A value.
- **RD_A:** present row 2r; go to RD_B.
- **RD_B:** capture rd_DI (row 2r) into row_a; present row 2r+1; go to WR.
- **WR:** rd_DI is row 2r+1. At the edge:
  - wr_wen <= 1.
  - wr_addr <= out_base + r, where out_base = ch*(row>>1).
  - wr_DO lane j = signed max(row_a[2j], row_a[2j+1], rd_DI[2j], rd_DI[2j+1]) for j < col>>1. Other lanes = 0.
  - If r == (row>>1)-1: done <= 1, increment the channel index, go to IDLE. Else r++ and go to RD_A.
- wr_wen and done are deasserted in every cycle not set by WR.
- Odd row: the last input row is never read. Odd col: the last lane is dropped. col > WORD_W/8 is clamped to WORD_W/8.
- Address arithmetic is modulo 2^ADDR_W.
- Reset mid-operation: outputs return to reset values immediately. The in-progress channel is abandoned and config is required again.

## Timing
- Cycle 1 = the first cycle after the accepting edge. ack is high in cycle 1.
- Output row r is written (wr_wen high) in cycle 3r+4.
- Throughput: 3 cycles per output row.
- The last write and done are high together in cycle 3·(row>>1)+1, and the state is IDLE in the same cycle.
- The next start may be sampled in that cycle.
- The degenerate start (row<2 or col<2) has done in cycle 1.

## Test plan
- **Basic pool.** Config ch=2, row=4, col=4. Buffer addr 0..3 = 0x04030201, 0x08070605, 0x80FF7F00, 0x01020304. Start. Required:
  - addr 0 ← 0x00000806 in cycle 4.
  - addr 1 ← 0x0000027F in cycle 7.
  - done in cycle 7.
- **Second channel and exhaustion.**
  - Second start reads addr 4..7 and writes addr 2, 3.
  - Third start gives ack with data_NA=1, no wr_wen and no done.
  - A following config clears data_NA.
- **Signed and odd col.** Config ch=1, row=2, col=4, rows 0xFFFEFDFC, 0x80818283: output 0x0000FFFD. Same data with col=3: output 0x000000FD.
- **Odd row.** row=5: exactly 2 writes, rd_addr never equals 4, done in cycle 7.
- **Busy / degenerate.**
  - Start or config issued in cycles 2..6 of a job gets no ack and does not disturb the results.
  - row=1 gives ack then done in cycle 1, with no writes.
- **Reset mid-job.** Deassert rst in cycle 5: all outputs are 0 at once. After release, start without config gives ack and data_NA=1 (channel=0), with no writes.
